// File: rtl/robo_cmd_if.sv
// robo_cmd_if: request handshakes, abort and actuator/status bundle of robo_cmd_scheduler.
interface robo_cmd_if #(parameter int CNT_W = 4);
  logic nav_valid;
  logic [1:0] nav_cmd;
  logic nav_ready;
  logic man_valid;
  logic [1:0] man_cmd;
  logic man_ready;
  logic man_stop;
  logic motor_fwd;
  logic motor_rot;
  logic arm_on;
  logic dump_on;
  logic busy;
  logic bin_full;
  logic [CNT_W-1:0] trash_count;
  modport master (
    output nav_valid, nav_cmd, man_valid, man_cmd, man_stop,
    input nav_ready, man_ready, motor_fwd, motor_rot, arm_on, dump_on, busy, bin_full, trash_count
  );
  modport slave (
    input nav_valid, nav_cmd, man_valid, man_cmd, man_stop,
    output nav_ready, man_ready, motor_fwd, motor_rot, arm_on, dump_on, busy, bin_full, trash_count
  );
endinterface

// File: rtl/robo_cmd_scheduler.sv
// robo_cmd_scheduler: arbitrates nav/manual drive commands, times actuator pulses, counts trash.
// Define BIN_DUMP_EN to add the automatic bin-dump sequence when the bin fills.
module robo_cmd_scheduler #(
  parameter int ADV_CYCLES = 8,
  parameter int TURN_CYCLES = 4,
  parameter int COLLECT_CYCLES = 6,
  parameter int DUMP_CYCLES = 10,
  parameter int BIN_CAP = 5,
  parameter int CNT_W = 4
) (
  input logic clock,
  input logic reset,
  robo_cmd_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DUMP} state_t;
  localparam int TW = 16;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(BIN_CAP);
`ifdef BIN_DUMP_EN
  localparam bit DUMP_EN = 1'b1;
`else
  localparam bit DUMP_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [1:0] cmd, cmd_n, req;
  logic [TW-1:0] timer, timer_n;
  logic [CNT_W-1:0] count_n;
  function automatic logic [TW-1:0] load(input logic [1:0] c);
    return c == 2'b01 ? TW'(ADV_CYCLES - 1) : c == 2'b10 ? TW'(TURN_CYCLES - 1) : TW'(COLLECT_CYCLES - 1);
  endfunction
  assign bus.man_ready = state == IDLE;
  assign bus.nav_ready = state == IDLE && !bus.man_valid;
  assign req = bus.man_valid && bus.man_ready ? bus.man_cmd :
               bus.nav_valid && bus.nav_ready ? bus.nav_cmd : 2'b00;
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    timer_n = timer;
    count_n = bus.trash_count;
    if (state == IDLE) begin
      if (req != 2'b00) begin
        state_n = RUN;
        cmd_n = req;
        timer_n = load(req);
      end
    end else if (state == RUN) begin
      if (bus.man_stop) state_n = IDLE;
      else if (timer == '0) begin
        state_n = IDLE;
        if (cmd == 2'b11 && bus.trash_count != CAP) count_n = bus.trash_count + 1'b1;
        if (DUMP_EN && cmd == 2'b11 && count_n == CAP) begin
          state_n = DUMP;
          timer_n = TW'(DUMP_CYCLES - 1);
        end
      end else timer_n = timer - 1'b1;
    end else begin
      if (timer == '0) begin
        state_n = IDLE;
        count_n = '0;
      end else timer_n = timer - 1'b1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cmd <= 2'b00;
      timer <= '0;
      bus.motor_fwd <= 1'b0;
      bus.motor_rot <= 1'b0;
      bus.arm_on <= 1'b0;
      bus.dump_on <= 1'b0;
      bus.busy <= 1'b0;
      bus.bin_full <= 1'b0;
      bus.trash_count <= '0;
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      timer <= timer_n;
      bus.motor_fwd <= state_n == RUN && cmd_n == 2'b01;
      bus.motor_rot <= state_n == RUN && cmd_n == 2'b10;
      bus.arm_on <= state_n == RUN && cmd_n == 2'b11;
      bus.dump_on <= DUMP_EN && state_n == DUMP;
      bus.busy <= state_n != IDLE;
      bus.bin_full <= count_n == CAP;
      bus.trash_count <= count_n;
    end
  end
endmodule

// File: tb/tb_robo_cmd_scheduler.sv
// tb_robo_cmd_scheduler: random/directed requests; expected actuator pulses go to a scoreboard queue.
module tb_robo_cmd_scheduler;
  localparam int ADV = 8, TURN = 4, COL = 6, DMP = 10, CAP = 5, CW = 4;
  typedef struct {int kind; int len; int cnt; int full;} exp_t;
  logic clock = 0;
  logic reset = 1;
  int compared = 0, mismatched = 0;
  int tc = 0;
  exp_t sbq[$];
  robo_cmd_if #(.CNT_W(CW)) bus();
  robo_cmd_scheduler #(.ADV_CYCLES(ADV), .TURN_CYCLES(TURN), .COLLECT_CYCLES(COL),
    .DUMP_CYCLES(DMP), .BIN_CAP(CAP), .CNT_W(CW)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask
  task automatic noise();
    bus.nav_valid = 1'($urandom);
    bus.nav_cmd = 2'($urandom);
    bus.man_valid = 1'($urandom);
    bus.man_cmd = 2'($urandom);
  endtask
  task automatic quiet();
    bus.nav_valid = 0;
    bus.man_valid = 0;
    bus.man_stop = 0;
  endtask
  // mode 0 nav only, 1 manual only, 2 both; k = run cycle on which man_stop is raised (0 none)
  task automatic op(input int mode, input logic [1:0] ncmd, input logic [1:0] mcmd, input int k_in, input bit rst_mid);
    logic [1:0] c;
    int d, k, len;
    bit dumping;
    @(negedge clock);
    bus.man_stop = 0;
    bus.nav_valid = mode != 1;
    bus.nav_cmd = ncmd;
    bus.man_valid = mode != 0;
    bus.man_cmd = mcmd;
    #1;
    chk("man_ready_idle", {31'd0, bus.man_ready}, 1);
    chk("nav_ready_idle", {31'd0, bus.nav_ready}, mode == 0);
    c = mode != 0 ? mcmd : ncmd;
    @(posedge clock);
    if (c == 2'b00) return;
    d = c == 2'b01 ? ADV : c == 2'b10 ? TURN : COL;
    k = k_in <= d ? k_in : 0;
    len = k != 0 ? k : d;
    dumping = 0;
    if (!rst_mid) begin
      if (c == 2'b11 && k == 0 && tc < CAP) tc++;
      sbq.push_back('{int'(c), len, tc, int'(tc == CAP)});
`ifdef BIN_DUMP_EN
      if (c == 2'b11 && k == 0 && tc == CAP) begin
        dumping = 1;
        sbq.push_back('{4, DMP, 0, 0});
        tc = 0;
      end
`endif
    end
    for (int i = 1; i <= len; i++) begin
      @(negedge clock);
      noise();
      bus.man_stop = i == k;
      if (rst_mid && i == 3) begin
        quiet();
        reset = 1;
        #1;
        chk("rst_async_fwd", {31'd0, bus.motor_fwd}, 0);
        chk("rst_async_busy", {31'd0, bus.busy}, 0);
        chk("rst_async_count", {28'd0, bus.trash_count}, 0);
        repeat (2) @(negedge clock);
        reset = 0;
        tc = 0;
        return;
      end
      if (i == 1) begin
        #1;
        chk("ready_in_run", {30'd0, bus.man_ready, bus.nav_ready}, 0);
      end
      @(posedge clock);
    end
    repeat (dumping ? DMP : 0) begin
      @(negedge clock);
      noise();
      bus.man_stop = 1'($urandom);
      @(posedge clock);
    end
  endtask
  int cur = 0, plen = 0;
  always @(negedge clock) begin
    int act;
    exp_t e;
    if (reset) begin
      cur = 0;
      plen = 0;
    end else begin
      act = bus.motor_fwd ? 1 : bus.motor_rot ? 2 : bus.arm_on ? 3 : bus.dump_on ? 4 : 0;
      chk("onehot_busy", {30'd0, $countones({bus.motor_fwd, bus.motor_rot, bus.arm_on, bus.dump_on}) <= 1, bus.busy},
          {30'd0, 1'b1, act != 0});
      if (cur != 0 && act != cur) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pulse: kind %0d len %0d with no expectation", cur, plen);
        end else begin
          e = sbq.pop_front();
          if (cur != e.kind || plen != e.len || int'(bus.trash_count) != e.cnt || int'(bus.bin_full) != e.full) begin
            mismatched++;
            $display("FAIL pulse: got kind %0d len %0d count %0d full %0d expected kind %0d len %0d count %0d full %0d",
                     cur, plen, bus.trash_count, bus.bin_full, e.kind, e.len, e.cnt, e.full);
          end
        end
      end
      if (act != cur) begin
        cur = act;
        plen = act != 0 ? 1 : 0;
      end else if (act != 0) plen++;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    quiet();
    bus.nav_cmd = 0;
    bus.man_cmd = 0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {25'd0, bus.motor_fwd, bus.motor_rot, bus.arm_on, bus.dump_on, bus.busy, bus.bin_full, 1'b0}, 0);
    chk("reset_count", {28'd0, bus.trash_count}, 0);
    reset = 0;
    op(0, 2'b01, 2'b00, 0, 0);
    op(2, 2'b01, 2'b10, 0, 0);
    op(0, 2'b01, 2'b00, 0, 0);
    op(1, 2'b00, 2'b11, COL, 0);
    for (int i = 0; i < 6; i++) op(i % 2, 2'b11, 2'b11, 0, 0);
    op(0, 2'b01, 2'b00, 0, 1);
    op(0, 2'b00, 2'b00, 0, 0);
    op(1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 200; i++) begin
      op($urandom_range(0, 2), 2'($urandom), 2'($urandom),
         $urandom_range(0, 3) == 0 ? $urandom_range(1, ADV) : 0, 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        quiet();
      end
    end
    @(negedge clock);
    quiet();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clock);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
